v_upd_tx: RTL and testbench

V_UPD_TX -- requirements
Module: v_upd_tx

---
 rtl/v_pkg.sv | 18 +
 rtl/v_upd_tx_q.sv | 58 +++++
 rtl/v_upd_tx.sv | 96 +++++++++
 tb/tb_v_upd_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared field types and constants for the list-engine update path.
// No latency or flow control: types and constants only.
package v_pkg;

    localparam int UPD_TX_DEPTH = 4;

    typedef logic [7:0]  id_t;
    typedef logic [3:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [11:0] size_t;

    localparam int UPD_PAY_W = $bits(id_t) + $bits(cmd_t) + $bits(key_t) + $bits(size_t);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/v_upd_tx_q.sv
// Request queue for v_upd_tx: DEPTH-entry FIFO; a pushed entry is poppable the next cycle.
// Pushes are refused while full, even in a cycle that also pops.
module v_upd_tx_q
    import v_pkg::*;
#(
    parameter int DEPTH = UPD_TX_DEPTH,
    parameter int W     = UPD_PAY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_empty_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic          push_acc;
    logic          pop_acc;

    // Extra pointer MSB tells a wrapped (full) queue apart from an empty one.
    assign o_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_empty  = (wr_ptr == rd_ptr);
    assign push_acc = i_push && !o_full;
    assign pop_acc  = i_pop && !o_empty;

    assign wr_ptr_nxt  = wr_ptr + PW'(push_acc);
    assign rd_ptr_nxt  = rd_ptr + PW'(pop_acc);
    assign o_empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    assign o_pop_dat   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

endmodule

// File: rtl/v_upd_tx.sv
// Queues update requests and issues them to the list engine; push-to-strobe 2 cycles, one update per 3 cycles.
// Backpressure: o_req_rdy drops while the queue is full; issue waits in IDLE while i_busy_r is high.
module v_upd_tx
    import v_pkg::*;
#(
    parameter int DEPTH = UPD_TX_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_vld,
    input  id_t         i_req_prod_id,
    input  cmd_t        i_req_cmd,
    input  key_t        i_req_key,
    input  size_t       i_req_size,
    output logic        o_req_rdy,
    output logic        o_upd_vld_r,
    output id_t         o_upd_prod_id_r,
    output cmd_t        o_upd_cmd_r,
    output key_t        o_upd_key_r,
    output size_t       o_upd_size_r,
    input  logic        i_busy_r,
    output logic        o_empty_r,
    output logic [15:0] o_issued_cnt_r
);

    logic [UPD_PAY_W-1:0] q_pop_dat;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_empty_nxt;
    logic                 pop_go;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [15:0]          issued_cnt_q;
    id_t                  pop_prod_id;
    cmd_t                 pop_cmd;
    key_t                 pop_key;
    size_t                pop_size;

    v_upd_tx_q #(
        .DEPTH (DEPTH),
        .W     (UPD_PAY_W)
    ) u_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (i_req_vld),
        .i_push_dat  ({i_req_prod_id, i_req_cmd, i_req_key, i_req_size}),
        .i_pop       (pop_go),
        .o_pop_dat   (q_pop_dat),
        .o_full      (q_full),
        .o_empty     (q_empty),
        .o_empty_nxt (q_empty_nxt)
    );

    assign o_req_rdy = !q_full;
    assign {pop_prod_id, pop_cmd, pop_key, pop_size} = q_pop_dat;

    // Busy only matters in IDLE; HOLD absorbs the engine's registered busy delay.
    assign pop_go = (state == ST_IDLE) && !q_empty && !i_busy_r;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pop_go) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
            issued_cnt_q    <= '0;
            o_empty_r       <= 1'b1;
        end else begin
            state       <= state_nxt;
            o_upd_vld_r <= pop_go;
            o_empty_r   <= q_empty_nxt && (state_nxt == ST_IDLE);
            if (pop_go) begin
                o_upd_prod_id_r <= pop_prod_id;
                o_upd_cmd_r     <= pop_cmd;
                o_upd_key_r     <= pop_key;
                o_upd_size_r    <= pop_size;
                issued_cnt_q    <= issued_cnt_q + 16'd1;
            end
        end
    end

    assign o_issued_cnt_r = issued_cnt_q;

endmodule

// File: tb/tb_v_upd_tx.sv
// Directed bench for v_upd_tx: reset, single issue, fill, busy gating, full+pop, reset mid-issue, counter wrap.
module tb_v_upd_tx;
    import v_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req_vld = 1'b0;
    id_t         i_req_prod_id = '0;
    cmd_t        i_req_cmd = '0;
    key_t        i_req_key = '0;
    size_t       i_req_size = '0;
    logic        o_req_rdy;
    logic        o_upd_vld_r;
    id_t         o_upd_prod_id_r;
    cmd_t        o_upd_cmd_r;
    key_t        o_upd_key_r;
    size_t       o_upd_size_r;
    logic        i_busy_r = 1'b0;
    logic        o_empty_r;
    logic [15:0] o_issued_cnt_r;

    int n_checks = 0;
    int n_fail   = 0;

    v_upd_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req_vld       (i_req_vld),
        .i_req_prod_id   (i_req_prod_id),
        .i_req_cmd       (i_req_cmd),
        .i_req_key       (i_req_key),
        .i_req_size      (i_req_size),
        .o_req_rdy       (o_req_rdy),
        .o_upd_vld_r     (o_upd_vld_r),
        .o_upd_prod_id_r (o_upd_prod_id_r),
        .o_upd_cmd_r     (o_upd_cmd_r),
        .o_upd_key_r     (o_upd_key_r),
        .o_upd_size_r    (o_upd_size_r),
        .i_busy_r        (i_busy_r),
        .o_empty_r       (o_empty_r),
        .o_issued_cnt_r  (o_issued_cnt_r)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input id_t id, input cmd_t c, input key_t k, input size_t s);
        i_req_vld     = v;
        i_req_prod_id = id;
        i_req_cmd     = c;
        i_req_key     = k;
        i_req_size    = s;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b exp 0", o_upd_vld_r); end
        n_checks++;
        if (o_empty_r !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", o_empty_r); end
        n_checks++;
        if (o_issued_cnt_r !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", o_issued_cnt_r); end
        n_checks++;
        if ({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r} !== '0) begin
            n_fail++; $display("FAIL reset_fields got %h/%h/%h/%h exp 0", o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r);
        end
        step();
        step();
        n_checks++;
        if (o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_during got %0b exp 1", o_req_rdy); end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL reset_post_vld got %0b exp 0", o_upd_vld_r); end
        n_checks++;
        if (o_req_rdy !== 1'b1 || o_empty_r !== 1'b1) begin
            n_fail++; $display("FAIL reset_post_rdy_empty got rdy=%0b empty=%0b exp 1/1", o_req_rdy, o_empty_r);
        end
    endtask

    task automatic test_single();
        i_busy_r = 1'b0;
        set_req(1'b1, 8'd3, 4'd1, 16'h0010, 12'd5);
        n_checks++;
        if (o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy got %0b exp 1", o_req_rdy); end
        step();
        set_req(1'b0, '0, '0, '0, '0);
        n_checks++;
        if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL single_vld_n1 got %0b exp 0", o_upd_vld_r); end
        step();
        n_checks++;
        if (o_upd_vld_r !== 1'b1) begin n_fail++; $display("FAIL single_vld_n2 got %0b exp 1", o_upd_vld_r); end
        n_checks++;
        if (o_upd_prod_id_r !== 8'd3 || o_upd_cmd_r !== 4'd1 || o_upd_key_r !== 16'h0010 || o_upd_size_r !== 12'd5) begin
            n_fail++; $display("FAIL single_fields got %h/%h/%h/%h exp 03/1/0010/005", o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r);
        end
        n_checks++;
        if (o_issued_cnt_r !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", o_issued_cnt_r); end
        step();
        n_checks++;
        if (o_upd_vld_r !== 1'b0 || o_upd_prod_id_r !== 8'd3 || o_upd_key_r !== 16'h0010) begin
            n_fail++; $display("FAIL single_hold got vld=%0b id=%h key=%h exp 0/03/0010", o_upd_vld_r, o_upd_prod_id_r, o_upd_key_r);
        end
        step();
        n_checks++;
        if (o_empty_r !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0b exp 1", o_empty_r); end
    endtask

    task automatic test_fill();
        logic exp_v;
        int   idx;
        i_busy_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, id_t'(8'h20 + i), cmd_t'(i), key_t'(16'h0100 + i), size_t'(i + 1));
            n_checks++;
            if (o_req_rdy !== (i < 4)) begin n_fail++; $display("FAIL fill_rdy[%0d] got %0b exp %0b", i, o_req_rdy, (i < 4)); end
            step();
        end
        set_req(1'b0, '0, '0, '0, '0);
        i_busy_r = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_v = (c % 3 == 1) && (c <= 10);
            n_checks++;
            if (o_upd_vld_r !== exp_v) begin n_fail++; $display("FAIL fill_vld[M+%0d] got %0b exp %0b", c, o_upd_vld_r, exp_v); end
            if (exp_v) begin
                idx = (c - 1) / 3;
                n_checks++;
                if (o_upd_prod_id_r !== id_t'(8'h20 + idx) || o_upd_key_r !== key_t'(16'h0100 + idx) ||
                    o_upd_size_r !== size_t'(idx + 1)) begin
                    n_fail++; $display("FAIL fill_order[%0d] got id=%h key=%h size=%h", idx, o_upd_prod_id_r, o_upd_key_r, o_upd_size_r);
                end
            end
        end
        n_checks++;
        if (o_issued_cnt_r !== 16'd5) begin n_fail++; $display("FAIL fill_cnt got %0d exp 5", o_issued_cnt_r); end
    endtask

    task automatic test_busy_gate();
        logic exp_v;
        i_busy_r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, id_t'(8'h40 + i), 4'hA, key_t'(16'h0400 + i), 12'd9);
            step();
        end
        set_req(1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL busy_no_strobe[%0d] got %0b exp 0", c, o_upd_vld_r); end
        end
        i_busy_r = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_v = (c == 1) || (c == 4);
            n_checks++;
            if (o_upd_vld_r !== exp_v) begin n_fail++; $display("FAIL busy_release_vld[M+%0d] got %0b exp %0b", c, o_upd_vld_r, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (o_upd_prod_id_r !== id_t'(c == 1 ? 8'h40 : 8'h41)) begin
                    n_fail++; $display("FAIL busy_release_id[M+%0d] got %h", c, o_upd_prod_id_r);
                end
            end
        end
        n_checks++;
        if (o_issued_cnt_r !== 16'd7) begin n_fail++; $display("FAIL busy_cnt got %0d exp 7", o_issued_cnt_r); end
    endtask

    task automatic test_full_pop();
        id_t  exp_id [5];
        logic exp_v;
        exp_id = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h5F};
        i_busy_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, id_t'(8'h50 + i), 4'h2, 16'h0500, 12'd1);
            step();
        end
        // Cycle M: pop happens at this edge, push offered while still full.
        i_busy_r = 1'b0;
        set_req(1'b1, 8'h5E, 4'h3, 16'h05EE, 12'd2);
        n_checks++;
        if (o_req_rdy !== 1'b0) begin n_fail++; $display("FAIL fullpop_rdy_M got %0b exp 0", o_req_rdy); end
        step();
        n_checks++;
        if (o_req_rdy !== 1'b1) begin n_fail++; $display("FAIL fullpop_rdy_M1 got %0b exp 1", o_req_rdy); end
        n_checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'h50) begin
            n_fail++; $display("FAIL fullpop_first got vld=%0b id=%h exp 1/50", o_upd_vld_r, o_upd_prod_id_r);
        end
        set_req(1'b1, 8'h5F, 4'h4, 16'h05FF, 12'd3);
        step();
        set_req(1'b0, '0, '0, '0, '0);
        for (int c = 2; c <= 14; c++) begin
            exp_v = (c % 3 == 1);
            n_checks++;
            if (o_upd_vld_r !== exp_v) begin n_fail++; $display("FAIL fullpop_vld[M+%0d] got %0b exp %0b", c, o_upd_vld_r, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (o_upd_prod_id_r !== exp_id[(c - 1) / 3]) begin
                    n_fail++; $display("FAIL fullpop_id[M+%0d] got %h exp %h", c, o_upd_prod_id_r, exp_id[(c - 1) / 3]);
                end
            end
            step();
        end
        n_checks++;
        if (o_issued_cnt_r !== 16'd12) begin n_fail++; $display("FAIL fullpop_cnt got %0d exp 12", o_issued_cnt_r); end
    endtask

    task automatic test_reset_mid();
        i_busy_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, id_t'(8'h60 + i), 4'h5, 16'h0600, 12'd4);
            step();
        end
        set_req(1'b0, '0, '0, '0, '0);
        i_busy_r = 1'b0;
        step();
        n_checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'h60) begin
            n_fail++; $display("FAIL rstmid_issue got vld=%0b id=%h exp 1/60", o_upd_vld_r, o_upd_prod_id_r);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld_drop got %0b exp 0", o_upd_vld_r); end
        n_checks++;
        if (o_empty_r !== 1'b1 || o_issued_cnt_r !== 16'd0 || o_req_rdy !== 1'b1 || o_upd_prod_id_r !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_state got empty=%0b cnt=%0d rdy=%0b id=%h exp 1/0/1/00",
                               o_empty_r, o_issued_cnt_r, o_req_rdy, o_upd_prod_id_r);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (o_upd_vld_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_replay[%0d] got %0b exp 0", c, o_upd_vld_r); end
        end
        n_checks++;
        if (o_empty_r !== 1'b1 || o_issued_cnt_r !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_after got empty=%0b cnt=%0d exp 1/0", o_empty_r, o_issued_cnt_r);
        end
    endtask

    task automatic test_wrap();
        force dut.issued_cnt_q = 16'hFFFF;
        #1;
        release dut.issued_cnt_q;
        step();
        i_busy_r = 1'b0;
        set_req(1'b1, 8'h71, 4'h6, 16'h0701, 12'd7);
        step();
        set_req(1'b1, 8'h72, 4'h7, 16'h0702, 12'd8);
        step();
        set_req(1'b0, '0, '0, '0, '0);
        n_checks++;
        if (o_upd_vld_r !== 1'b1 || o_issued_cnt_r !== 16'h0000 || o_upd_prod_id_r !== 8'h71) begin
            n_fail++; $display("FAIL wrap_first got vld=%0b cnt=%h id=%h exp 1/0000/71", o_upd_vld_r, o_issued_cnt_r, o_upd_prod_id_r);
        end
        step();
        step();
        step();
        n_checks++;
        if (o_upd_vld_r !== 1'b1 || o_issued_cnt_r !== 16'h0001 || o_upd_prod_id_r !== 8'h72 || o_upd_size_r !== 12'd8) begin
            n_fail++; $display("FAIL wrap_second got vld=%0b cnt=%h id=%h size=%h exp 1/0001/72/008",
                               o_upd_vld_r, o_issued_cnt_r, o_upd_prod_id_r, o_upd_size_r);
        end
        step();
        step();
        n_checks++;
        if (o_empty_r !== 1'b1 || o_req_rdy !== 1'b1 || o_upd_vld_r !== 1'b0) begin
            n_fail++; $display("FAIL wrap_idle got empty=%0b rdy=%0b vld=%0b exp 1/1/0", o_empty_r, o_req_rdy, o_upd_vld_r);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_busy_gate();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
